bakery_controller: RTL and testbench
====================================

Name: bakery_controller

Overview:
Recipe sequencer that drives the bakery plant model from the controller side. It consumes the plant's Y_* sensor outputs and generates its X_* control inputs. It runs one batch per start pulse: fill, dose, mix, dispense into pans, drain, then an optional wash. It sits beside the plant in the FPGA top and replaces manual switch control.

Parameters:
FLOUR_DOSES, 4, flour doses per batch (1..15)
SALT_DOSES, 2, salt doses per batch (1..15)
MIX_CYCLES, 64, enabled cycles X_mixer is held in mix phases (>=16)
COVER_CYCLES, 32, enabled cycles X_cover is held before the cover counts as closed
PANS, 4, pans to fill per batch (1..15)
TIMEOUT, 1023, maximum enabled cycles waiting on any sensor before fault

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
en  in  1  clock enable; all state advances only when en=1
start  in  1  begin batch (sampled in IDLE only)
Y_water_base, Y_water_middle, Y_water_top  in  1 each  level sensors from plant
Y_flour, Y_salt  in  1 each  feeder delivering (ack)
Y_flour_remain, Y_salt_remain  in  1 each  feeder stock present
Y_pan, Y_pan_full  in  1 each  pan under dispenser / pan full
X_water, X_drain, X_flour, X_salt, X_mixer, X_cover, X_pressurize, X_dispenser, X_pan_conveyor  out  1 each  plant controls
busy  out  1  batch in progress
done  out  1  one-cycle pulse on batch completion
fault  out  1  sticky fault flag
fault_code  out  3  0 none, 1 water timeout, 2 flour, 3 salt, 4 pan timeout, 5 drain timeout, 6 overflow
state  out  4  current FSM state, for inspection

Behaviour:
- Reset: state=IDLE; all X_*, busy, done, fault=0; fault_code=0; all counters=0. rst overrides en.
- All outputs are registered. Timer reloads to 0 on every state change and increments each enabled cycle.
- IDLE: start=1 -> FILL. busy=1 in every state except IDLE and FAULT.
- FILL: X_water=1 until Y_water_middle=1 -> FLOUR.
- FLOUR: needs Y_flour_remain=1, otherwise fault 2. Pulse X_flour for one cycle, then wait for Y_flour to rise and then fall. That counts one dose. Repeat until the dose count = FLOUR_DOSES -> SALT.
- SALT: same protocol with X_salt/Y_salt/Y_salt_remain. Fault 3. At SALT_DOSES -> COVER.
- COVER: X_cover=1 for COVER_CYCLES -> MIX. X_cover stays 1 through MIX.
- MIX: X_mixer=1 and X_pressurize=1 for MIX_CYCLES, then drop all three -> DISPENSE.
- DISPENSE: X_pan_conveyor=1 until Y_pan=1. Then conveyor=0 and X_dispenser=1 until Y_pan_full=1. Then dispenser=0, pan count+1. When pan count = PANS or Y_water_base=0 -> DRAIN; otherwise repeat.
- DRAIN: X_drain=1 until Y_water_base=0 -> WASH (feature on) or FINISH.
- WASH_FILL: X_water until Y_water_middle. WASH_MIX: X_mixer for MIX_CYCLES. WASH_DRAIN: X_drain until Y_water_base=0 -> FINISH.
- FINISH: done=1 for one enabled cycle -> IDLE.
- Timeout: if a wait on a sensor reaches TIMEOUT, go to FAULT with the matching code. Codes: FILL/WASH_FILL=1, feeders=2/3, DISPENSE=4, drains=5.
- Overflow: Y_water_top=1 in any state except IDLE and FAULT -> FAULT with code 6. Overflow takes priority over every other transition in the same cycle.
- FAULT: all X_* forced to 0 except X_drain=1. Stays in FAULT until rst. start is ignored.
- start asserted while busy is ignored. en=0 freezes the FSM, timer, and outputs.
- Dose and pan counters are 4 bits and never wrap, because parameter range is bounded.

Optional Feature:
BAKERY_CTRL_WASH_EN: when defined, DRAIN is followed by the WASH_FILL/WASH_MIX/WASH_DRAIN states. When undefined, those states are not compiled and DRAIN goes directly to FINISH.

Test Plan:
- Nominal batch with a responsive plant model, FLOUR_DOSES=4, SALT_DOSES=2, PANS=4 -> exactly 4 X_flour pulses, 2 X_salt pulses, X_mixer high 64 cycles, 4 Y_pan_full handshakes, done pulses once, fault=0.
- Y_flour_remain=0 at entry to FLOUR -> fault=1, fault_code=2, X_drain=1, all other X_*=0.
- Y_water_middle never rises -> fault_code=1 exactly 1023 enabled cycles after entering FILL.
- Y_water_top pulses high during MIX -> FAULT with code 6 on the next cycle; X_mixer drops.
- en toggled 50% during a batch -> same output sequence as the nominal run, stretched; no lost doses.
- rst asserted mid-DISPENSE -> next cycle state=IDLE, all outputs 0; a new start runs a clean batch. With BAKERY_CTRL_WASH_EN defined, the state output visits WASH_* states before FINISH.

Source files
------------

// File: rtl/bakery_controller.sv
`default_nettype none
// ============================================================================
// Module      : bakery_controller
// Description : Batch recipe sequencer for the bakery plant. It runs fill,
//               dose, mix, dispense and drain, then an optional wash
//               (BAKERY_CTRL_WASH_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module bakery_controller #(
    parameter int FLOUR_DOSES  = 4,
    parameter int SALT_DOSES   = 2,
    parameter int MIX_CYCLES   = 64,
    parameter int COVER_CYCLES = 32,
    parameter int PANS         = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       Y_water_base,
    input  logic       Y_water_middle,
    input  logic       Y_water_top,
    input  logic       Y_flour,
    input  logic       Y_salt,
    input  logic       Y_flour_remain,
    input  logic       Y_salt_remain,
    input  logic       Y_pan,
    input  logic       Y_pan_full,
    output logic       X_water,
    output logic       X_drain,
    output logic       X_flour,
    output logic       X_salt,
    output logic       X_mixer,
    output logic       X_cover,
    output logic       X_pressurize,
    output logic       X_dispenser,
    output logic       X_pan_conveyor,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FILL       = 4'd1,
        S_FLOUR      = 4'd2,
        S_SALT       = 4'd3,
        S_COVER      = 4'd4,
        S_MIX        = 4'd5,
        S_DISPENSE   = 4'd6,
        S_DRAIN      = 4'd7,
        S_WASH_FILL  = 4'd8,
        S_WASH_MIX   = 4'd9,
        S_WASH_DRAIN = 4'd10,
        S_FINISH     = 4'd11,
        S_FAULT      = 4'd12
    } state_t;

    // Sub-phases: feeder states use CHECK/PULSE/RISE/FALL, DISPENSE uses CONVEY/FILLPAN
    localparam logic [1:0] c_PH_CHECK   = 2'd0;
    localparam logic [1:0] c_PH_PULSE   = 2'd1;
    localparam logic [1:0] c_PH_RISE    = 2'd2;
    localparam logic [1:0] c_PH_FALL    = 2'd3;
    localparam logic [1:0] c_PH_CONVEY  = 2'd0;
    localparam logic [1:0] c_PH_FILLPAN = 2'd1;

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] c_COVER_LAST   = 16'(COVER_CYCLES - 1);
    localparam logic [15:0] c_MIX_LAST     = 16'(MIX_CYCLES - 1);
    localparam logic [3:0]  c_FLOUR_DOSES  = 4'(FLOUR_DOSES);
    localparam logic [3:0]  c_SALT_DOSES   = 4'(SALT_DOSES);
    localparam logic [3:0]  c_PANS         = 4'(PANS);

    localparam logic [2:0] c_FC_NONE     = 3'd0;
    localparam logic [2:0] c_FC_WATER    = 3'd1;
    localparam logic [2:0] c_FC_FLOUR    = 3'd2;
    localparam logic [2:0] c_FC_SALT     = 3'd3;
    localparam logic [2:0] c_FC_PAN      = 3'd4;
    localparam logic [2:0] c_FC_DRAIN    = 3'd5;
    localparam logic [2:0] c_FC_OVERFLOW = 3'd6;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_phase, w_phase_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic [3:0]  r_doses, w_doses_nxt;
    logic [3:0]  r_pans, w_pans_nxt;
    logic [2:0]  r_fault_code, w_code_nxt;
    logic [2:0]  w_wait_code;
    logic        w_feed_ack, w_feed_remain;
    logic [2:0]  w_feed_code;
    logic [3:0]  w_feed_target;
    state_t      w_feed_after;
    logic [11:0] r_out, w_out_nxt;

    // FLOUR and SALT share one handshake; only the sensor set differs
    assign w_feed_ack    = (r_state == S_SALT) ? Y_salt        : Y_flour;
    assign w_feed_remain = (r_state == S_SALT) ? Y_salt_remain : Y_flour_remain;
    assign w_feed_code   = (r_state == S_SALT) ? c_FC_SALT     : c_FC_FLOUR;
    assign w_feed_target = (r_state == S_SALT) ? c_SALT_DOSES  : c_FLOUR_DOSES;
    assign w_feed_after  = (r_state == S_SALT) ? S_COVER       : S_SALT;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_doses_nxt = r_doses;
        w_pans_nxt  = r_pans;
        w_code_nxt  = r_fault_code;
        w_wait_code = c_FC_NONE;

        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_FILL;
            S_FILL: begin
                w_wait_code = c_FC_WATER;
                if (Y_water_middle) w_state_nxt = S_FLOUR;
            end
            S_FLOUR, S_SALT: begin
                case (r_phase)
                    c_PH_CHECK: begin
                        if (!w_feed_remain) begin
                            w_state_nxt = S_FAULT;
                            w_code_nxt  = w_feed_code;
                        end else begin
                            w_phase_nxt = c_PH_PULSE;
                        end
                    end
                    c_PH_PULSE: w_phase_nxt = c_PH_RISE;
                    c_PH_RISE: begin
                        w_wait_code = w_feed_code;
                        if (w_feed_ack) w_phase_nxt = c_PH_FALL;
                    end
                    default: begin
                        w_wait_code = w_feed_code;
                        if (!w_feed_ack) begin
                            if (r_doses + 4'd1 == w_feed_target) begin
                                w_state_nxt = w_feed_after;
                            end else begin
                                w_doses_nxt = r_doses + 4'd1;
                                w_phase_nxt = c_PH_CHECK;
                            end
                        end
                    end
                endcase
            end
            S_COVER: if (r_timer == c_COVER_LAST) w_state_nxt = S_MIX;
            S_MIX:   if (r_timer == c_MIX_LAST)   w_state_nxt = S_DISPENSE;
            S_DISPENSE: begin
                w_wait_code = c_FC_PAN;
                if (r_phase == c_PH_CONVEY) begin
                    if (Y_pan) w_phase_nxt = c_PH_FILLPAN;
                end else if (Y_pan_full) begin
                    if ((r_pans + 4'd1 == c_PANS) || !Y_water_base) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_pans_nxt  = r_pans + 4'd1;
                        w_phase_nxt = c_PH_CONVEY;
                    end
                end
            end
            S_DRAIN: begin
                w_wait_code = c_FC_DRAIN;
`ifdef BAKERY_CTRL_WASH_EN
                if (!Y_water_base) w_state_nxt = S_WASH_FILL;
`else
                if (!Y_water_base) w_state_nxt = S_FINISH;
`endif
            end
`ifdef BAKERY_CTRL_WASH_EN
            S_WASH_FILL: begin
                w_wait_code = c_FC_WATER;
                if (Y_water_middle) w_state_nxt = S_WASH_MIX;
            end
            S_WASH_MIX: if (r_timer == c_MIX_LAST) w_state_nxt = S_WASH_DRAIN;
            S_WASH_DRAIN: begin
                w_wait_code = c_FC_DRAIN;
                if (!Y_water_base) w_state_nxt = S_FINISH;
            end
`endif
            S_FINISH: w_state_nxt = S_IDLE;
            default: ;
        endcase

        // A sensor that answers on the last allowed cycle still wins over the timeout
        if ((w_wait_code != c_FC_NONE) && (w_state_nxt == r_state) &&
            (w_phase_nxt == r_phase) && (r_timer == c_TIMEOUT_LAST)) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = w_wait_code;
        end
        if (Y_water_top && (r_state != S_IDLE) && (r_state != S_FAULT)) begin
            w_state_nxt = S_FAULT;
            w_code_nxt  = c_FC_OVERFLOW;
        end
        if (w_state_nxt != r_state) begin
            w_phase_nxt = '0;
            w_doses_nxt = '0;
            w_pans_nxt  = '0;
        end

        if ((w_state_nxt != r_state) || (w_phase_nxt != r_phase) ||
            (w_state_nxt == S_IDLE) || (w_state_nxt == S_FAULT))
            w_timer_nxt = '0;
        else
            w_timer_nxt = r_timer + 16'd1;

        // Outputs are decoded from the upcoming state so they register alongside it
        w_out_nxt     = '0;
        w_out_nxt[11] = (w_state_nxt == S_FILL) || (w_state_nxt == S_WASH_FILL);
        w_out_nxt[10] = (w_state_nxt == S_DRAIN) || (w_state_nxt == S_WASH_DRAIN) ||
                        (w_state_nxt == S_FAULT);
        w_out_nxt[9]  = (w_state_nxt == S_FLOUR) && (w_phase_nxt == c_PH_PULSE);
        w_out_nxt[8]  = (w_state_nxt == S_SALT)  && (w_phase_nxt == c_PH_PULSE);
        w_out_nxt[7]  = (w_state_nxt == S_MIX) || (w_state_nxt == S_WASH_MIX);
        w_out_nxt[6]  = (w_state_nxt == S_COVER) || (w_state_nxt == S_MIX);
        w_out_nxt[5]  = (w_state_nxt == S_MIX);
        w_out_nxt[4]  = (w_state_nxt == S_DISPENSE) && (w_phase_nxt == c_PH_FILLPAN);
        w_out_nxt[3]  = (w_state_nxt == S_DISPENSE) && (w_phase_nxt == c_PH_CONVEY);
        w_out_nxt[2]  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FAULT);
        w_out_nxt[1]  = (w_state_nxt == S_FINISH);
        w_out_nxt[0]  = (w_state_nxt == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_timer      <= '0;
            r_doses      <= '0;
            r_pans       <= '0;
            r_fault_code <= c_FC_NONE;
            r_out        <= '0;
        end else if (en) begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_timer      <= w_timer_nxt;
            r_doses      <= w_doses_nxt;
            r_pans       <= w_pans_nxt;
            r_fault_code <= w_code_nxt;
            r_out        <= w_out_nxt;
        end
    end

    assign {X_water, X_drain, X_flour, X_salt, X_mixer, X_cover, X_pressurize,
            X_dispenser, X_pan_conveyor, busy, done, fault} = r_out;
    assign fault_code = r_fault_code;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bakery_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bakery_controller
// Description : Self-checking bench for bakery_controller with a reactive
//               plant model and a scoreboard of per-batch expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bakery_controller;
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FILL     = 4'd1;
    localparam logic [3:0] ST_MIX      = 4'd5;
    localparam logic [3:0] ST_DISPENSE = 4'd6;
    localparam logic [3:0] ST_FAULT    = 4'd12;

    logic clk = 1'b0;
    logic rst, en, start;
    logic Y_water_base, Y_water_middle, Y_water_top, Y_flour, Y_salt;
    logic Y_flour_remain, Y_salt_remain, Y_pan, Y_pan_full;
    logic X_water, X_drain, X_flour, X_salt, X_mixer, X_cover, X_pressurize;
    logic X_dispenser, X_pan_conveyor, busy, done, fault;
    logic [2:0] fault_code;
    logic [3:0] state;

    logic y_top_lvl, force_top;
    assign Y_water_top = y_top_lvl | force_top;

    logic [7:0]  x_others;
    logic [11:0] all_out;
    assign x_others = {X_water, X_flour, X_salt, X_mixer, X_cover, X_pressurize,
                       X_dispenser, X_pan_conveyor};
    assign all_out  = {X_water, X_drain, X_flour, X_salt, X_mixer, X_cover, X_pressurize,
                       X_dispenser, X_pan_conveyor, busy, done, fault};

    bakery_controller dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .Y_water_base(Y_water_base), .Y_water_middle(Y_water_middle),
        .Y_water_top(Y_water_top), .Y_flour(Y_flour), .Y_salt(Y_salt),
        .Y_flour_remain(Y_flour_remain), .Y_salt_remain(Y_salt_remain),
        .Y_pan(Y_pan), .Y_pan_full(Y_pan_full),
        .X_water(X_water), .X_drain(X_drain), .X_flour(X_flour), .X_salt(X_salt),
        .X_mixer(X_mixer), .X_cover(X_cover), .X_pressurize(X_pressurize),
        .X_dispenser(X_dispenser), .X_pan_conveyor(X_pan_conveyor),
        .busy(busy), .done(done), .fault(fault), .fault_code(fault_code), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Plant configuration and monitors
    bit en_half = 1'b0;
    bit water_stuck = 1'b0;
    int base_kill = 0;
    int lvl = 0, fl_cnt = 0, sa_cnt = 0, conv_cnt = 0, disp_cnt = 0;
    bit prev_flour = 1'b0, prev_salt = 1'b0, wash_seen = 1'b0;
    int n_flour = 0, n_salt = 0, n_mix = 0, n_pans = 0, n_done = 0;

    typedef struct {
        bit         en_half;
        bit         flour_rem;
        bit         salt_rem;
        int         base_kill;
        logic [2:0] exp_code;
        int         exp_flour;
        int         exp_salt;
        int         exp_mix;
        int         exp_pans;
        int         exp_done;
    } vec_t;

    typedef struct {
        logic [2:0] code;
        int         flour;
        int         salt;
        int         mix;
        int         pans;
        int         done_cnt;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic plant_step();
        if (rst) begin
            lvl = 0; fl_cnt = 0; sa_cnt = 0; conv_cnt = 0; disp_cnt = 0;
            Y_pan = 1'b0; Y_pan_full = 1'b0; prev_flour = 1'b0; prev_salt = 1'b0;
        end else begin
            if (X_water && !water_stuck) lvl++;
            if (X_drain && lvl > 0) lvl--;
            if (X_flour && !prev_flour) begin fl_cnt = 6; n_flour++; end
            if (X_salt && !prev_salt) begin sa_cnt = 6; n_salt++; end
            prev_flour = X_flour;
            prev_salt  = X_salt;
            if (fl_cnt > 0) fl_cnt--;
            if (sa_cnt > 0) sa_cnt--;
            if (X_pan_conveyor) begin
                Y_pan_full = 1'b0;
                disp_cnt = 0;
                conv_cnt++;
                Y_pan = (conv_cnt >= 3);
            end
            if (X_dispenser) begin
                conv_cnt = 0;
                disp_cnt++;
                if (disp_cnt >= 4 && !Y_pan_full) begin Y_pan_full = 1'b1; n_pans++; end
            end
            if (en && X_mixer && state == ST_MIX) n_mix++;
            if (en && done) n_done++;
            if (state >= 4'd8 && state <= 4'd10) wash_seen = 1'b1;
        end
        Y_flour        = (fl_cnt >= 1) && (fl_cnt <= 3);
        Y_salt         = (sa_cnt >= 1) && (sa_cnt <= 3);
        Y_water_middle = (lvl >= 10);
        y_top_lvl      = (lvl >= 20);
        Y_water_base   = (lvl > 0) && !(base_kill > 0 && n_pans >= base_kill);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            plant_step();
        end
    end

    // en changes just after the active edge so it is stable across the next one
    initial begin
        en = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            en = en_half ? ~en : 1'b1;
        end
    end

    task automatic clear_mon();
        n_flour = 0; n_salt = 0; n_mix = 0; n_pans = 0; n_done = 0; wash_seen = 1'b0;
    endtask

    task automatic set_cfg(input vec_t v);
        en_half = v.en_half;
        Y_flour_remain = v.flour_rem;
        Y_salt_remain = v.salt_rem;
        base_kill = v.base_kill;
        water_stuck = 1'b0;
        force_top = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (state != ST_IDLE) break;
        end
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_state(input logic [3:0] st, input string name);
        bit hit = 1'b0;
        for (int k = 0; k < 5000 && !hit; k++) begin
            @(negedge clk);
            if (state == st) hit = 1'b1;
        end
        check(name, hit, 1);
    endtask

    task automatic run_vec(input vec_t v, input bit do_reset);
        exp_t e;
        bit   finished;
        set_cfg(v);
        if (do_reset) pulse_reset();
        clear_mon();
        e = '{v.exp_code, v.exp_flour, v.exp_salt, v.exp_mix, v.exp_pans, v.exp_done};
        sb.push_back(e);
        launch();
        finished = 1'b0;
        for (int k = 0; k < 20000 && !finished; k++) begin
            @(negedge clk);
            if (state == ST_FAULT || (state == ST_IDLE && n_done > 0)) finished = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("batch_end_reached", finished, 1);
        e = sb.pop_front();
        check("fault_code", fault_code, e.code);
        check("fault_flag", fault, (e.code != 3'd0) ? 1 : 0);
        check("flour_pulses", n_flour, e.flour);
        check("salt_pulses", n_salt, e.salt);
        check("mixer_cycles", n_mix, e.mix);
        check("pan_handshakes", n_pans, e.pans);
        check("done_pulses", n_done, e.done_cnt);
        if (e.code != 3'd0) begin
            check("fault_x_others", x_others, 0);
            check("fault_x_drain", X_drain, 1);
        end
    endtask

    initial begin
        //          en_h flour salt kill code fl sa mix pans done
        vecs[0] = '{1'b0, 1'b1, 1'b1, 0, 3'd0, 4, 2, 64, 4, 1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 0, 3'd0, 4, 2, 64, 4, 1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 0, 3'd2, 0, 0, 0,  0, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 0, 3'd3, 4, 0, 0,  0, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 2, 3'd0, 4, 2, 64, 2, 1};

        rst = 1'b1; start = 1'b0; force_top = 1'b0;
        Y_flour_remain = 1'b1; Y_salt_remain = 1'b1;
        Y_water_base = 1'b0; Y_water_middle = 1'b0; y_top_lvl = 1'b0;
        Y_flour = 1'b0; Y_salt = 1'b0; Y_pan = 1'b0; Y_pan_full = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", state, ST_IDLE);
        check("reset_outputs", all_out, 0);
        check("reset_fault_code", fault_code, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], 1'b1);
            if (i == 0) begin
`ifdef BAKERY_CTRL_WASH_EN
                check("wash_visited", wash_seen, 1);
`else
                check("wash_skipped", wash_seen, 0);
`endif
            end
        end

        // FILL timeout: water never reaches the middle sensor
        set_cfg(vecs[0]);
        water_stuck = 1'b1;
        pulse_reset();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("fill_entered", state, ST_FILL);
        repeat (1022) @(posedge clk);
        @(negedge clk);
        check("fill_before_timeout", state, ST_FILL);
        @(posedge clk);
        @(negedge clk);
        check("fill_timeout_state", state, ST_FAULT);
        check("fill_timeout_code", fault_code, 1);
        check("fill_timeout_drain", X_drain, 1);
        check("fill_timeout_others", x_others, 0);

        // Overflow during MIX
        set_cfg(vecs[0]);
        pulse_reset();
        launch();
        wait_state(ST_MIX, "mix_reached");
        repeat (5) @(negedge clk);
        force_top = 1'b1;
        @(negedge clk);
        force_top = 1'b0;
        check("overflow_state", state, ST_FAULT);
        check("overflow_code", fault_code, 6);
        check("overflow_mixer", X_mixer, 0);
        check("overflow_others", x_others, 0);
        check("overflow_drain", X_drain, 1);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("fault_ignores_start", state, ST_FAULT);

        // Reset in the middle of DISPENSE, then a clean batch without extra reset
        set_cfg(vecs[0]);
        pulse_reset();
        launch();
        wait_state(ST_DISPENSE, "dispense_reached");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", state, ST_IDLE);
        check("midrst_outputs", all_out, 0);
        check("midrst_fault_code", fault_code, 0);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
